// File: rtl/rob_pkg.sv
// Shared reorder-buffer types and default sizing.
// Entry record holds valid/done/dest; dest width follows the default register count.
package rob_pkg;

    localparam int ROB_SIZE_DEF  = 32;
    localparam int ARCH_REGS_DEF = 32;
    localparam int ROB_IDX_W     = $clog2(ROB_SIZE_DEF);
    localparam int REG_IDX_W     = $clog2(ARCH_REGS_DEF);
    localparam int ROB_PORTS     = 3;

    typedef struct packed {
        logic                 valid;
        logic                 done;
        logic [REG_IDX_W-1:0] dest;
    } rob_entry_t;

endpackage

// File: rtl/rob_retire_sel.sv
// Retire selector: counts contiguous valid+done entries from head, up to three.
// Latency: purely combinational.
// Backpressure: none; the scan stops at the first entry that is invalid or not done.
module rob_retire_sel
    import rob_pkg::*;
#(
    parameter int  ROB_SIZE = ROB_SIZE_DEF,
    localparam int IW       = $clog2(ROB_SIZE)
) (
    input  logic [IW-1:0]           head,
    input  logic [ROB_SIZE-1:0]     valid_vec,
    input  logic [ROB_SIZE-1:0]     done_vec,
    output logic [1:0]              retire_num,
    output logic [ROB_PORTS*IW-1:0] retire_tag
);

    logic [IW-1:0] h0, h1, h2;
    logic          r0, r1, r2;

    // ROB_SIZE >= 4 keeps these three indices distinct even when wrapping.
    assign h0 = head;
    assign h1 = head + IW'(1);
    assign h2 = head + IW'(2);

    assign r0 = valid_vec[h0] & done_vec[h0];
    assign r1 = r0 & valid_vec[h1] & done_vec[h1];
    assign r2 = r1 & valid_vec[h2] & done_vec[h2];

    assign retire_num = r2 ? 2'd3 : (r1 ? 2'd2 : (r0 ? 2'd1 : 2'd0));

    assign retire_tag = {r2 ? h2 : IW'(0), r1 ? h1 : IW'(0), r0 ? h0 : IW'(0)};

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: 3-wide dispatch, completion and in-order retirement. Optional flush via ROB_FLUSH_EN.
// Latency: dispatch/complete/retire take effect at the next edge; tail and retire outputs are combinational.
// Backpressure: a dispatch larger than the free count is dropped whole; rob_stall warns below 3 free.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int  ROB_SIZE  = ROB_SIZE_DEF,
    parameter int  ARCH_REGS = ARCH_REGS_DEF,
    localparam int IW        = $clog2(ROB_SIZE),
    localparam int RW        = $clog2(ARCH_REGS)
) (
    input  logic                    clk,
    input  logic                    reset,
`ifdef ROB_FLUSH_EN
    input  logic                    flush_in,
`endif
    input  logic                    dispatch_en,
    input  logic [1:0]              rob_dispatch_num,
    input  logic [ROB_PORTS*RW-1:0] dest_reg_idx_in,
    input  logic                    complete_en,
    input  logic [ROB_PORTS*IW-1:0] CDB_tag_in,
    input  logic [1:0]              rob_complete_num,
    output logic [IW-1:0]           rob_tail_out,
    output logic [IW:0]             rob_free_slots,
    output logic                    rob_stall,
    output logic [1:0]              retire_num,
    output logic [ROB_PORTS*IW-1:0] retire_tag,
    output logic [ROB_PORTS*RW-1:0] retire_dest_reg
);

    localparam int CW = IW + 1;

    rob_entry_t          ent [ROB_SIZE];
    logic [IW-1:0]       head;
    logic [IW-1:0]       tail;
    logic [CW-1:0]       count;
    logic                clr;
    logic                disp_ok;
    logic [1:0]          disp_n;
    logic [ROB_SIZE-1:0] valid_vec;
    logic [ROB_SIZE-1:0] done_vec;

`ifdef ROB_FLUSH_EN
    assign clr = reset | flush_in;
`else
    assign clr = reset;
`endif

    // Free count comes from registered state only; this cycle's retires show up next cycle.
    assign rob_free_slots = CW'(ROB_SIZE) - count;
    assign rob_stall      = rob_free_slots < CW'(3);
    assign disp_ok        = dispatch_en && (CW'(rob_dispatch_num) <= rob_free_slots);
    assign disp_n         = disp_ok ? rob_dispatch_num : 2'd0;
    assign rob_tail_out   = tail + IW'(rob_dispatch_num) - IW'(1);

    always_comb begin
        valid_vec = '0;
        done_vec  = '0;
        for (int k = 0; k < ROB_SIZE; k++) begin
            valid_vec[k] = ent[k].valid;
            done_vec[k]  = ent[k].done;
        end
    end

    rob_retire_sel #(
        .ROB_SIZE (ROB_SIZE)
    ) u_retire_sel (
        .head       (head),
        .valid_vec  (valid_vec),
        .done_vec   (done_vec),
        .retire_num (retire_num),
        .retire_tag (retire_tag)
    );

    always_comb begin
        retire_dest_reg = '0;
        for (int i = 0; i < ROB_PORTS; i++) begin
            if (2'(i) < retire_num) begin
                retire_dest_reg[i*RW +: RW] = RW'(ent[retire_tag[i*IW +: IW]].dest);
            end
        end
    end

    // Completions, retires and dispatches never touch the same entry in one cycle:
    // retiring entries are already done, and dispatch targets only invalid slots.
    always_ff @(posedge clk) begin
        if (clr) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int k = 0; k < ROB_SIZE; k++) begin
                ent[k] <= '0;
            end
        end else begin
            for (int j = 0; j < ROB_PORTS; j++) begin
                if (complete_en && (2'(j) < rob_complete_num) &&
                    ent[CDB_tag_in[j*IW +: IW]].valid) begin
                    ent[CDB_tag_in[j*IW +: IW]].done <= 1'b1;
                end
            end
            for (int i = 0; i < ROB_PORTS; i++) begin
                if (2'(i) < retire_num) begin
                    ent[head + IW'(i)].valid <= 1'b0;
                    ent[head + IW'(i)].done  <= 1'b0;
                end
            end
            for (int i = 0; i < ROB_PORTS; i++) begin
                if (2'(i) < disp_n) begin
                    ent[tail + IW'(i)] <= '{valid: 1'b1, done: 1'b0,
                                            dest: REG_IDX_W'(dest_reg_idx_in[i*RW +: RW])};
                end
            end
            head  <= head + IW'(retire_num);
            tail  <= tail + IW'(disp_n);
            count <= count + CW'(disp_n) - CW'(retire_num);
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer (ROB_SIZE=8): directed scenarios then random traffic,
// all compared against a queue/array reference model.
module tb_reorder_buffer;

    localparam int RS = 8;
    localparam int AR = 32;
    localparam int IW = 3;
    localparam int RW = 5;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        dispatch_en;
    logic [1:0]  rob_dispatch_num;
    logic [14:0] dest_reg_idx_in;
    logic        complete_en;
    logic [8:0]  CDB_tag_in;
    logic [1:0]  rob_complete_num;
    logic [2:0]  rob_tail_out;
    logic [3:0]  rob_free_slots;
    logic        rob_stall;
    logic [1:0]  retire_num;
    logic [8:0]  retire_tag;
    logic [14:0] retire_dest_reg;
`ifdef ROB_FLUSH_EN
    logic        flush_in;
`endif

    reorder_buffer #(.ROB_SIZE(RS), .ARCH_REGS(AR)) dut (
        .clk              (clk),
        .reset            (reset),
`ifdef ROB_FLUSH_EN
        .flush_in         (flush_in),
`endif
        .dispatch_en      (dispatch_en),
        .rob_dispatch_num (rob_dispatch_num),
        .dest_reg_idx_in  (dest_reg_idx_in),
        .complete_en      (complete_en),
        .CDB_tag_in       (CDB_tag_in),
        .rob_complete_num (rob_complete_num),
        .rob_tail_out     (rob_tail_out),
        .rob_free_slots   (rob_free_slots),
        .rob_stall        (rob_stall),
        .retire_num       (retire_num),
        .retire_tag       (retire_tag),
        .retire_dest_reg  (retire_dest_reg)
    );

    // Reference model: occupancy as plain arrays plus head/tail/count integers.
    bit m_valid [RS];
    bit m_done  [RS];
    int m_dest  [RS];
    int m_head, m_tail, m_count;

    int n_err    = 0;
    int n_checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < RS; k++) begin
            m_valid[k] = 1'b0;
            m_done[k]  = 1'b0;
            m_dest[k]  = 0;
        end
        m_head  = 0;
        m_tail  = 0;
        m_count = 0;
    endtask

    function automatic int model_ready();
        int n = 0;
        while (n < 3 && m_valid[(m_head + n) % RS] && m_done[(m_head + n) % RS]) n++;
        return n;
    endfunction

    task automatic model_check();
        int          n;
        logic [8:0]  et;
        logic [14:0] ed;
        n  = model_ready();
        et = '0;
        ed = '0;
        for (int i = 0; i < n; i++) begin
            et[i*3 +: 3] = 3'((m_head + i) % RS);
            ed[i*5 +: 5] = 5'(m_dest[(m_head + i) % RS]);
        end
        chk("free_slots", 32'(rob_free_slots), 32'(RS - m_count));
        chk("stall",      32'(rob_stall),      32'((RS - m_count) < 3));
        chk("tail_out",   32'(rob_tail_out),   32'((m_tail + int'(rob_dispatch_num) + RS - 1) % RS));
        chk("retire_num", 32'(retire_num),     32'(n));
        chk("retire_tag", 32'(retire_tag),     32'(et));
        chk("retire_dest",32'(retire_dest_reg),32'(ed));
    endtask

    task automatic model_update();
        bit clear;
        int n, dn, t;
        clear = reset;
`ifdef ROB_FLUSH_EN
        clear = clear | flush_in;
`endif
        if (clear) begin
            model_clear();
        end else begin
            n = model_ready();
            if (complete_en) begin
                for (int j = 0; j < int'(rob_complete_num); j++) begin
                    t = int'(CDB_tag_in[j*3 +: 3]);
                    if (m_valid[t]) m_done[t] = 1'b1;
                end
            end
            for (int i = 0; i < n; i++) begin
                m_valid[(m_head + i) % RS] = 1'b0;
                m_done[(m_head + i) % RS]  = 1'b0;
            end
            dn = int'(rob_dispatch_num);
            if (dispatch_en && dn <= RS - m_count) begin
                for (int i = 0; i < dn; i++) begin
                    m_valid[(m_tail + i) % RS] = 1'b1;
                    m_done[(m_tail + i) % RS]  = 1'b0;
                    m_dest[(m_tail + i) % RS]  = int'(dest_reg_idx_in[i*5 +: 5]);
                end
                m_tail  = (m_tail + dn) % RS;
                m_count = m_count + dn;
            end
            m_head  = (m_head + n) % RS;
            m_count = m_count - n;
        end
    endtask

    task automatic tick();
        #1;
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive(input bit de, input int dn, input int d0, input int d1, input int d2,
                         input bit ce, input int cn, input int t0, input int t1, input int t2);
        dispatch_en      = de;
        rob_dispatch_num = 2'(dn);
        dest_reg_idx_in  = {5'(d2), 5'(d1), 5'(d0)};
        complete_en      = ce;
        rob_complete_num = 2'(cn);
        CDB_tag_in       = {3'(t2), 3'(t1), 3'(t0)};
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 0, 0, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int pend[$];
        int tg[3];
        reset = 1'b1;
`ifdef ROB_FLUSH_EN
        flush_in = 1'b0;
`endif
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();

        // Reset state
        #1;
        chk("rst_free",  32'(rob_free_slots),  32'd8);
        chk("rst_stall", 32'(rob_stall),       32'd0);
        chk("rst_rnum",  32'(retire_num),      32'd0);
        chk("rst_rtag",  32'(retire_tag),      32'd0);
        chk("rst_rdest", 32'(retire_dest_reg), 32'd0);

        // Dispatch two (r1, r2) from empty
        drive(1'b1, 2, 1, 2, 0, 1'b0, 0, 0, 0, 0);
        #1 chk("first_tail_out", 32'(rob_tail_out), 32'd1);
        tick();

        // Complete tag 1 first, then tag 0; retire must wait for the registered done
        drive(1'b0, 0, 0, 0, 0, 1'b1, 1, 1, 0, 0);
        #1 chk("free_after_two", 32'(rob_free_slots), 32'd6);
        tick();
        drive(1'b0, 0, 0, 0, 0, 1'b1, 1, 0, 0, 0);
        #1 chk("rnum_head_pending", 32'(retire_num), 32'd0);
        tick();
        idle();
        #1;
        chk("rnum_pair",  32'(retire_num),      32'd2);
        chk("rtag_pair",  32'(retire_tag),      32'(0 | (1 << 3)));
        chk("rdest_pair", 32'(retire_dest_reg), 32'(1 | (2 << 5)));
        tick();
        #1 chk("free_after_retire", 32'(rob_free_slots), 32'd8);
        tick();

        // Fill 3,3,2 then an overflowing dispatch is dropped
        do_reset();
        drive(1'b1, 3, 3, 4, 5, 1'b0, 0, 0, 0, 0); tick();
        drive(1'b1, 3, 6, 7, 8, 1'b0, 0, 0, 0, 0); tick();
        drive(1'b1, 2, 9, 10, 0, 1'b0, 0, 0, 0, 0); tick();
        drive(1'b1, 1, 11, 0, 0, 1'b0, 0, 0, 0, 0);
        #1;
        chk("full_free",  32'(rob_free_slots), 32'd0);
        chk("full_stall", 32'(rob_stall),      32'd1);
        tick();
        idle();
        #1 chk("drop_free", 32'(rob_free_slots), 32'd0);
        tick();

        // Wrap: move head/tail to 6, fill, retire 3 across the wrap, dispatch 2
        do_reset();
        drive(1'b1, 3, 1, 2, 3, 1'b0, 0, 0, 0, 0); tick();
        drive(1'b1, 3, 4, 5, 6, 1'b0, 0, 0, 0, 0); tick();
        drive(1'b0, 0, 0, 0, 0, 1'b1, 3, 0, 1, 2); tick();
        drive(1'b0, 0, 0, 0, 0, 1'b1, 3, 3, 4, 5); tick();
        idle(); tick();
        drive(1'b1, 3, 10, 11, 12, 1'b0, 0, 0, 0, 0); tick();
        drive(1'b1, 3, 13, 14, 15, 1'b0, 0, 0, 0, 0); tick();
        drive(1'b1, 2, 16, 17, 0, 1'b0, 0, 0, 0, 0); tick();
        drive(1'b0, 0, 0, 0, 0, 1'b1, 3, 6, 7, 0);
        #1 chk("wrap_full", 32'(rob_free_slots), 32'd0);
        tick();
        idle();
        #1;
        chk("wrap_rnum",  32'(retire_num),      32'd3);
        chk("wrap_rtag",  32'(retire_tag),      32'(6 | (7 << 3) | (0 << 6)));
        chk("wrap_rdest", 32'(retire_dest_reg), 32'(10 | (11 << 5) | (12 << 10)));
        tick();
        drive(1'b1, 2, 20, 21, 0, 1'b0, 0, 0, 0, 0);
        #1 chk("wrap_tail_out", 32'(rob_tail_out), 32'd7);
        tick();
        idle();
        #1 chk("wrap_free", 32'(rob_free_slots), 32'd1);
        tick();

`ifdef ROB_FLUSH_EN
        // Flush beats a concurrent dispatch
        drive(1'b1, 3, 1, 2, 3, 1'b0, 0, 0, 0, 0);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        idle();
        #1;
        chk("flush_free", 32'(rob_free_slots), 32'd8);
        chk("flush_rnum", 32'(retire_num),     32'd0);
        tick();
`endif

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            pend.delete();
            for (int k = 0; k < RS; k++) if (m_valid[k] && !m_done[k]) pend.push_back(k);
            for (int j = 0; j < 3; j++) begin
                if (pend.size() > 0 && $urandom_range(0, 3) != 0)
                    tg[j] = pend[$urandom_range(0, pend.size() - 1)];
                else
                    tg[j] = int'($urandom_range(0, RS - 1));
            end
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  $urandom_range(0, 4) != 0, int'($urandom_range(0, 3)), tg[0], tg[1], tg[2]);
            reset = ($urandom_range(0, 99) == 0);
`ifdef ROB_FLUSH_EN
            flush_in = ($urandom_range(0, 79) == 0);
`endif
            tick();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_SIZE, default 32, entry count, power of two, at least 4.
REQ-002 SHALL have parameter ARCH_REGS, default 32, architectural register count.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port dispatch_en  input  1  dispatch request qualifier.
REQ-006 SHALL have port rob_dispatch_num  input  2  instructions dispatched this cycle (0..3).
REQ-007 SHALL have port dest_reg_idx_in  input  3 x clog2(ARCH_REGS)  destination register per slot.
REQ-008 SHALL have port complete_en  input  1  completion qualifier.
REQ-009 SHALL have port CDB_tag_in  input  3 x clog2(ROB_SIZE)  completing ROB tags.
REQ-010 SHALL have port rob_complete_num  input  2  valid CDB tags (slots 0..n-1).
REQ-011 SHALL have port rob_tail_out  output  clog2(ROB_SIZE)  index of the last entry allocated this cycle.
REQ-012 SHALL have port rob_free_slots  output  clog2(ROB_SIZE)+1  free entries.
REQ-013 SHALL have port rob_stall  output  1  high when rob_free_slots < 3.
REQ-014 SHALL have ports retire_num (2), retire_tag (3 x clog2(ROB_SIZE)), retire_dest_reg (3 x clog2(ARCH_REGS))  outputs  in-order retirement group.

Function
REQ-015 SHALL keep per-entry valid, done and dest fields, plus head, tail and count registers.
REQ-016 SHALL accept a dispatch only when dispatch_en=1 and rob_dispatch_num <= rob_free_slots; otherwise drop the whole request with no state change.
REQ-017 SHALL allocate slot i at (tail+i) mod ROB_SIZE for i < rob_dispatch_num, set valid=1 and done=0, and advance tail by rob_dispatch_num at the next edge.
REQ-018 SHALL drive rob_tail_out combinationally as (tail + rob_dispatch_num - 1) mod ROB_SIZE, so dest slot i receives tag rob_tail_out - rob_dispatch_num + 1 + i, the tag convention the map table expects.
REQ-019 SHALL set done=1 at the next edge for each CDB_tag_in[j] with j < rob_complete_num and complete_en=1 whose entry is valid; tags for invalid entries are ignored.
REQ-020 SHALL drive retire_num combinationally as the count of contiguous valid and done entries from head, capped at 3, with retire_tag and retire_dest_reg filled for slots below retire_num and zero above.
REQ-021 SHALL clear valid for retired entries and advance head by retire_num at the next edge.
REQ-022 SHALL compute rob_free_slots from the registered count only; slots retired this cycle become free the next cycle.
REQ-023 SHALL update count as count + accepted dispatch - retire_num when dispatch and retire occur in the same cycle.
REQ-024 SHALL wrap all pointers and tag arithmetic modulo ROB_SIZE.
REQ-025 SHALL distinguish full from empty via count: full when count = ROB_SIZE, empty when count = 0.
REQ-026 SHALL not retire an entry in the same cycle it completes; done is registered first.

Reset
REQ-027 SHALL, on reset=1, clear head, tail, count and all valid/done bits at the next edge, overriding any concurrent dispatch or complete.
REQ-028 SHALL, after reset, drive rob_free_slots=ROB_SIZE, rob_stall=0, retire_num=0, retire_tag=0 and retire_dest_reg=0.

Configuration
REQ-029 SHALL, with ROB_FLUSH_EN defined, add port flush_in (input, 1 bit); flush_in=1 clears state as reset does at the next edge and has priority over dispatch and complete.
REQ-030 SHALL, without ROB_FLUSH_EN, have no flush_in port and no flush logic.

Structure
REQ-031 SHALL take ROB_SIZE/ARCH_REGS defaults, derived index widths and the rob_entry_t struct (valid, done, dest) from the shared package rob_pkg.
REQ-032 SHALL place the contiguous-done head scan (up to 3 entries, modular indexing) in sub-module rob_retire_sel.

Verification
REQ-033 Reset with ROB_SIZE=8 -> rob_free_slots=8, rob_stall=0, retire_num=0.
REQ-034 From empty, dispatch num=2 with dest r1,r2 -> same cycle rob_tail_out=1; next cycle rob_free_slots=6.
REQ-035 Complete tag 1 -> retire_num stays 0; complete tag 0 next cycle -> following cycle retire_num=2, retire_tag={0,1}, retire_dest_reg={r1,r2}.
REQ-036 Dispatch 3, 3, 2 from empty -> free=0 and rob_stall=1; then dispatch num=1 -> dropped, count stays 8.
REQ-037 Wrap case: head=6, tail=6 (full), retire 3 while dispatching 0 -> head=1; then dispatch 2 -> rob_tail_out=7, tags 6,7.
REQ-038 ROB_FLUSH_EN defined, flush_in=1 while a dispatch of 3 is requested -> next cycle free=8 and no entry valid.
